// File: rtl/button_press_classifier_pkg.sv
// rtl/button_press_classifier_pkg.sv - shared state encoding and default timing constants
package button_press_classifier_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    localparam int DEFAULT_CNT_WIDTH    = 16;
    localparam int DEFAULT_LONG_TICKS   = 1000;
    localparam int DEFAULT_REPEAT_TICKS = 200;

endpackage

// File: rtl/button_press_classifier_press_timer.sv
// rtl/button_press_classifier_press_timer.sv - tick counter that flags and restarts on its terminal tick
module press_timer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] limit_i,
    output logic                 done_o
);

    logic [CNT_WIDTH-1:0] count;

    assign done_o = en_i & (count == (limit_i - CNT_WIDTH'(1)));

    // Restarting on done keeps the count below the active limit at all times.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            count <= '0;
        end else if (done_o) begin
            count <= '0;
        end else if (en_i) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/button_press_classifier.sv
// rtl/button_press_classifier.sv - classifies debounced presses into short, long and auto-repeat events
module button_press_classifier
    import button_press_classifier_pkg::*;
#(
    parameter int CNT_WIDTH    = DEFAULT_CNT_WIDTH,
    parameter int LONG_TICKS   = DEFAULT_LONG_TICKS,
    parameter int REPEAT_TICKS = DEFAULT_REPEAT_TICKS
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       sw_state_i,
    input  logic       sw_down_i,
    input  logic       sw_up_i,
    output logic       short_o,
    output logic       long_o,
    output logic       repeat_o,
    output logic       held_o,
    output logic [7:0] event_count_o
);

    state_t               state;
    logic                 timer_done;
    logic [CNT_WIDTH-1:0] timer_limit;

    // The timer idles at zero, so entering PRESSED always starts a fresh hold.
    assign timer_limit = (state == LONG_HELD) ? CNT_WIDTH'(REPEAT_TICKS) : CNT_WIDTH'(LONG_TICKS);

    press_timer #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_press_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (state == IDLE),
        .en_i   (tick_i && (state != IDLE)),
        .limit_i(timer_limit),
        .done_o (timer_done)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            short_o       <= 1'b0;
            long_o        <= 1'b0;
            repeat_o      <= 1'b0;
            held_o        <= 1'b0;
            event_count_o <= 8'd0;
        end else begin
            short_o  <= 1'b0;
            long_o   <= 1'b0;
            repeat_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sw_down_i) begin
                        state  <= PRESSED;
                        held_o <= 1'b1;
                    end else begin
                        held_o <= 1'b0;
                    end
                end
                PRESSED: begin
                    // Release outranks a coincident terminal tick.
                    if (sw_up_i) begin
                        state         <= IDLE;
                        held_o        <= 1'b0;
                        short_o       <= 1'b1;
                        event_count_o <= event_count_o + 8'd1;
                    end else if (!sw_state_i) begin
                        state  <= IDLE;
                        held_o <= 1'b0;
                    end else if (timer_done) begin
                        state         <= LONG_HELD;
                        held_o        <= 1'b1;
                        long_o        <= 1'b1;
                        event_count_o <= event_count_o + 8'd1;
                    end else begin
                        held_o <= 1'b1;
                    end
                end
                LONG_HELD: begin
                    if (sw_up_i || !sw_state_i) begin
                        state  <= IDLE;
                        held_o <= 1'b0;
                    end else begin
                        held_o <= 1'b1;
                        if (timer_done) begin
                            repeat_o      <= 1'b1;
                            event_count_o <= event_count_o + 8'd1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    held_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_press_classifier.sv
// tb/tb_button_press_classifier.sv - scoreboard bench for button_press_classifier
module tb_button_press_classifier;

    localparam int LT = 4;
    localparam int RT = 2;

    logic       clk = 1'b0;
    logic       rst, tick, sw_state, sw_down, sw_up;
    logic       short_o, long_o, repeat_o, held_o;
    logic [7:0] event_count_o;

    always #5 clk = ~clk;

    button_press_classifier #(
        .CNT_WIDTH   (16),
        .LONG_TICKS  (LT),
        .REPEAT_TICKS(RT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tick_i       (tick),
        .sw_state_i   (sw_state),
        .sw_down_i    (sw_down),
        .sw_up_i      (sw_up),
        .short_o      (short_o),
        .long_o       (long_o),
        .repeat_o     (repeat_o),
        .held_o       (held_o),
        .event_count_o(event_count_o)
    );

    typedef struct packed {
        logic       s;
        logic       l;
        logic       r;
        logic       h;
        logic [7:0] c;
    } exp_t;

    exp_t       sb[$];
    exp_t       obs;
    int         checks = 0;
    int         errors = 0;
    int         m_state = 0;
    int         m_timer = 0;
    logic [7:0] m_cnt = 8'd0;

    task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Drive one cycle, push the reference outcome, then compare after the edge.
    task automatic cyc(input logic r, input logic t, input logic s, input logic d, input logic u);
        exp_t e;
        rst = r; tick = t; sw_state = s; sw_down = d; sw_up = u;
        e = '0;
        if (r) begin
            m_state = 0; m_timer = 0; m_cnt = 8'd0;
        end else begin
            if (m_state == 0) begin
                if (d) begin m_state = 1; m_timer = 0; end
            end else if (m_state == 1) begin
                if (u) begin e.s = 1'b1; m_state = 0; end
                else if (!s) m_state = 0;
                else if (t) begin
                    if (m_timer == LT - 1) begin e.l = 1'b1; m_timer = 0; m_state = 2; end
                    else m_timer++;
                end
            end else begin
                if (u || !s) m_state = 0;
                else if (t) begin
                    if (m_timer == RT - 1) begin e.r = 1'b1; m_timer = 0; end
                    else m_timer++;
                end
            end
            if (e.s || e.l || e.r) m_cnt = m_cnt + 8'd1;
        end
        e.h = (m_state != 0);
        e.c = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        obs = {short_o, long_o, repeat_o, held_o, event_count_o};
        e = sb.pop_front();
        chk("short_o", obs.s, e.s);
        chk("long_o", obs.l, e.l);
        chk("repeat_o", obs.r, e.r);
        chk("held_o", obs.h, e.h);
        chk("event_count_o", obs.c, e.c);
        chk("one_pulse_max", 8'((obs.s + obs.l + obs.r) <= 1), 8'd1);
    endtask

    task automatic do_reset();
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; tick = 1'b1; sw_state = 1'b0; sw_down = 1'b0; sw_up = 1'b0;

        // Reset, then a stray release
        do_reset();
        chk("reset_count", obs.c, 8'd0);
        chk("reset_held", obs.h, 1'b0);
        cyc(0, 1, 0, 0, 1);
        chk("stray_up_short", obs.s, 1'b0);

        // Short press
        cyc(0, 1, 1, 1, 0);
        chk("short_held_t1", obs.h, 1'b1);
        cyc(0, 1, 1, 0, 0);
        chk("short_held_t2", obs.h, 1'b1);
        cyc(0, 1, 0, 0, 1);
        chk("short_pulse_t3", obs.s, 1'b1);
        chk("short_count", obs.c, 8'd1);
        chk("short_held_t3", obs.h, 1'b0);
        cyc(0, 1, 0, 0, 0);
        chk("short_gone_t4", obs.s, 1'b0);

        // Long press with auto-repeat
        do_reset();
        cyc(0, 1, 1, 1, 0);
        for (int i = 1; i <= 9; i++) begin
            cyc(0, 1, 1, 0, 0);
            chk("long_at_t5", obs.l, 1'(i == 4));
            chk("repeat_t7_t9", obs.r, 1'(i == 6 || i == 8));
        end
        cyc(0, 1, 0, 0, 1);
        chk("long_release_nopulse", obs.s | obs.l | obs.r, 1'b0);
        chk("long_release_held", obs.h, 1'b0);
        chk("long_count", obs.c, 8'd3);

        // Release coincident with the terminal tick
        do_reset();
        cyc(0, 1, 1, 1, 0);
        for (int i = 1; i <= 3; i++) cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 1);
        chk("simul_short", obs.s, 1'b1);
        chk("simul_long", obs.l, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 0);
            chk("simul_no_long", obs.l, 1'b0);
        end

        // Sparse ticks with redundant sw_down that must not restart the hold
        do_reset();
        cyc(0, 0, 1, 1, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 1, 1, 1, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 1, 0, 0);
        chk("sparse_long", obs.l, 1'b1);
        cyc(0, 0, 0, 0, 1);

        // Event counter wrap
        do_reset();
        for (int i = 0; i < 255; i++) begin
            cyc(0, 1, 1, 1, 0);
            cyc(0, 1, 0, 0, 1);
        end
        chk("wrap_255", obs.c, 8'd255);
        cyc(0, 1, 1, 1, 0);
        cyc(0, 1, 0, 0, 1);
        chk("wrap_short", obs.s, 1'b1);
        chk("wrap_zero", obs.c, 8'd0);

        // Reset while in LONG_HELD
        do_reset();
        cyc(0, 1, 1, 1, 0);
        for (int i = 1; i <= 5; i++) cyc(0, 1, 1, 0, 0);
        chk("pre_reset_long_held", obs.h, 1'b1);
        cyc(1, 1, 1, 0, 0);
        chk("midrst_held", obs.h, 1'b0);
        chk("midrst_count", obs.c, 8'd0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 1, 0, 0);
            chk("midrst_no_repeat", obs.r | obs.l, 1'b0);
        end
        cyc(0, 1, 0, 0, 1);
        chk("midrst_up_nopulse", obs.s, 1'b0);

        // Lost release while PRESSED
        cyc(0, 1, 1, 1, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("lost_release_held", obs.h, 1'b0);
        chk("lost_release_short", obs.s, 1'b0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);
        chk("lost_release_count", obs.c, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_press_classifier.md
BUTTON_PRESS_CLASSIFIER -- requirements
Module: button_press_classifier

Interface
REQ-001 Parameter CNT_WIDTH, 16: width of the internal hold timer.
REQ-002 Parameter LONG_TICKS, 1000: number of tick_i strobes held before a long press; range 1..2^CNT_WIDTH-1.
REQ-003 Parameter REPEAT_TICKS, 200: number of tick_i strobes between auto-repeat pulses after a long press; range 1..2^CNT_WIDTH-1.
REQ-004 clk_i  input  1  the single clock; all logic on its rising edge.
REQ-005 rst_i  input  1  reset; synchronous and active-high.
REQ-006 tick_i  input  1  timebase strobe, one clk_i cycle wide (e.g. 1 ms).
REQ-007 sw_state_i  input  1  debounced button level, 1 = pressed.
REQ-008 sw_down_i  input  1  one-cycle debounced press pulse.
REQ-009 sw_up_i  input  1  one-cycle debounced release pulse.
REQ-010 short_o  output  1  one-cycle pulse: press released before reaching long.
REQ-011 long_o  output  1  one-cycle pulse: hold reached LONG_TICKS.
REQ-012 repeat_o  output  1  one-cycle pulse: every REPEAT_TICKS while still held after long.
REQ-013 held_o  output  1  level: the classifier is in PRESSED or LONG_HELD.
REQ-014 event_count_o  output  8  count of short_o + long_o + repeat_o pulses issued.

Function
REQ-015 The state machine SHALL have three states: IDLE, PRESSED and LONG_HELD.
REQ-016 IDLE: sw_down_i SHALL go to PRESSED and clear the timer; sw_up_i and tick_i SHALL be ignored.
REQ-017 PRESSED: each tick_i SHALL increment the timer.
REQ-018 PRESSED: a tick_i arriving with the timer at LONG_TICKS-1 SHALL assert long_o, clear the timer and go to LONG_HELD.
REQ-019 PRESSED: sw_up_i SHALL assert short_o and go to IDLE.
REQ-020 LONG_HELD: each tick_i SHALL increment the timer.
REQ-021 LONG_HELD: a tick_i arriving with the timer at REPEAT_TICKS-1 SHALL assert repeat_o and clear the timer.
REQ-022 LONG_HELD: sw_up_i SHALL return to IDLE with no pulse.
REQ-023 Release priority: sw_up_i in the same cycle as a terminal tick SHALL win. In PRESSED this gives short_o only; in LONG_HELD it gives no pulse.
REQ-024 sw_down_i in PRESSED or LONG_HELD SHALL be ignored; the timer SHALL NOT be cleared.
REQ-025 Lost-release recovery: sw_state_i == 0 in PRESSED or LONG_HELD without sw_up_i SHALL return to IDLE with no pulse.
REQ-026 All outputs SHALL be registered.
REQ-027 Latency: each pulse SHALL appear exactly one clk_i cycle after the triggering input cycle, and SHALL last exactly one cycle.
REQ-028 held_o SHALL equal (next state != IDLE), registered.
REQ-029 event_count_o SHALL increment by 1 per pulse issued and SHALL wrap from 255 to 0.
REQ-030 At most one of short_o, long_o and repeat_o SHALL be high in any cycle.
REQ-031 The timer SHALL never exceed max(LONG_TICKS, REPEAT_TICKS)-1.

Reset
REQ-032 While rst_i is high at a clock edge, the state SHALL become IDLE, the timer 0, and every output 0 (including event_count_o), on the next edge.
REQ-033 Reset asserted mid-press SHALL discard the press; a later sw_up_i SHALL produce no pulse.
REQ-034 Nothing SHALL be updated asynchronously; rst_i SHALL NOT appear in any sensitivity list.

Structure
REQ-035 The shared package SHALL hold the state encoding (IDLE=2'd0, PRESSED=2'd1, LONG_HELD=2'd2) and the default LONG_TICKS and REPEAT_TICKS constants.
REQ-036 One sub-module, press_timer, SHALL be used. Ports: clk_i, rst_i, clr_i, en_i, limit_i [CNT_WIDTH-1:0], done_o. done_o = en_i & (count == limit_i-1).
REQ-037 The FSM and output registers SHALL stay in button_press_classifier.

Verification (LONG_TICKS=4, REPEAT_TICKS=2, tick_i=1 every cycle unless noted)
REQ-038 Reset: rst_i high 2 cycles -> all outputs 0, event_count_o=0; then sw_up_i alone -> no pulse.
REQ-039 Short press: sw_down_i at t0, sw_up_i at t2 -> short_o high at t3 only, held_o 1 for t1..t2, event_count_o=1.
REQ-040 Long with repeat: sw_down_i at t0, hold -> long_o at t5; repeat_o at t7 and t9; sw_up_i at t10 -> no pulse, held_o=0 at t11, event_count_o=3.
REQ-041 Simultaneous: sw_up_i coincides with the 4th tick -> short_o only, long_o never.
REQ-042 Wrap: event_count_o=255, then short press -> event_count_o=0.
REQ-043 Mid-operation reset and recovery: rst_i during LONG_HELD -> outputs 0 next cycle, no repeat_o afterwards. Separately, sw_state_i dropped without sw_up_i in PRESSED -> IDLE, no pulse.
